// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch vs execute data, one transaction in flight.
// Optional fetch anti-starvation counter is enabled by defining MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_mask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_mask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("STARVE_MAX must be in 1..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic [1:0] {O_NONE, O_IF, O_DATA} owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [3:0]        r_mem_mask;

  logic w_d_req;
  logic w_accept;
  logic w_resp;
  logic w_if_win;

  assign w_d_req  = d_read | d_write;
  assign w_accept = r_mem_req & mem_ready;
  assign w_resp   = (r_state == S_RESP) & mem_rvalid;

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] r_starve;

  // Fetch overrides data once STARVE_MAX data grants went by while it waited
  assign w_if_win = if_req &
    (~w_d_req | (r_starve == 4'(STARVE_MAX)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (if_gnt) begin
      r_starve <= '0;
    end else if (d_gnt & if_req) begin
      r_starve <= r_starve + 4'd1;
    end else if ((r_state == S_IDLE) & ~if_req) begin
      r_starve <= '0;
    end
  end
`else
  assign w_if_win = if_req & ~w_d_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= O_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_if_win) begin
            r_owner     <= O_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_mask  <= 4'hF;
            r_state     <= S_REQ;
          end else if (w_d_req) begin
            r_owner     <= O_DATA;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_write;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
            r_mem_mask  <= d_write ? d_mask : 4'hF;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_state <= S_IDLE;
              r_owner <= O_NONE;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (mem_rvalid) begin
            r_state <= S_IDLE;
            r_owner <= O_NONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_owner <= O_NONE;
        end
      endcase
    end
  end

  assign if_gnt    = w_accept & (r_owner == O_IF);
  assign d_gnt     = w_accept & (r_owner == O_DATA);
  assign if_rvalid = w_resp & (r_owner == O_IF);
  assign d_rvalid  = w_resp & (r_owner == O_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign stall_out = w_d_req & ~d_gnt;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_mask  = r_mem_mask;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between instruction fetch and the execute stage's data access (load/store issued from the execute stage's registered memory outputs). One transaction outstanding at a time; data accesses win by default, with optional anti-starvation for fetch. Sits between the pipeline stages and the unified memory model. Drives a stall to the pipeline while a data access waits.

## Interface
- DATA_W, 32, address/data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (fairness build only); legal range 1..15
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  DATA_W  fetch address
- if_gnt  out  1  fetch request accepted by memory (1-cycle pulse)
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- d_read  in  1  data load request; held until d_gnt
- d_write  in  1  data store request; held until d_gnt
- d_addr  in  DATA_W  data address
- d_wdata  in  DATA_W  store data
- d_mask  in  4  store byte enables
- d_gnt  out  1  data request accepted (1-cycle pulse)
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- stall_out  out  1  data request pending and not granted this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  write (1) / read (0)
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_mask  out  4  byte enables (reads: 4'hF)
- mem_ready  in  1  memory accepts request when mem_req & mem_ready
- mem_rvalid  in  1  read response valid (≥1 cycle after accept)
- mem_rdata  in  DATA_W  read response data

## Operation
- FSM states: IDLE, REQ, RESP. Owner register: NONE, IF, DATA.
- IDLE: if any request, pick winner, latch address/data/mask/we into registered mem_* outputs, set owner, go REQ. No request: stay.
- Priority: data over fetch. d_read & d_write both asserted: treated as write, no d_rvalid generated.
- REQ: mem_req=1, outputs stable. On mem_ready: pulse owner's gnt (combinational, same cycle as accept); write → IDLE, read → RESP.
- RESP: wait mem_rvalid; route mem_rdata/rvalid to owner only (other rvalid=0); → IDLE same cycle.
- mem_rvalid outside RESP ignored. mem_req=0 in IDLE and RESP.
- stall_out = (d_read | d_write) & ~d_gnt.
- Reset mid-operation: FSM → IDLE, owner NONE, in-flight response discarded; memory side must tolerate abandoned request.

## Timing
- Reset values: mem_req 0, mem_we 0, mem_addr/wdata 0, mem_mask 0, all gnt/rvalid 0, rdata 0, stall_out follows inputs (combinational).
- Request seen cycle N (IDLE) → mem_req high cycle N+1; with mem_ready=1 gnt in N+1.
- Read with 1-cycle memory latency: rvalid to requester at N+2; next arbitration at N+3 (IDLE then takes one cycle).
- Write, mem_ready=1: back-to-back transactions every 2 cycles.
- Requester inputs sampled only in IDLE; changes during REQ/RESP have no effect.

## Configuration
- MEM_ARB_FAIR_EN defined: 4-bit starve counter increments on each data grant while if_req is high at that grant, clears on fetch grant or when if_req low in IDLE; when counter == STARVE_MAX, fetch wins next IDLE arbitration even if data pending. Reset clears counter.
- Not defined: fixed data priority; fetch can starve indefinitely; no counter logic.

## Test plan
- Fetch only: if_req, if_addr=0x100, mem_ready=1, mem_rdata=0xDEADBEEF one cycle after accept → if_gnt at N+1, if_rvalid with 0xDEADBEEF at N+2, d_rvalid stays 0.
- Simultaneous: if_req and d_write (addr 0x2000, wdata 0x55AA, mask 0x3) → store issued first with mem_we=1, mem_mask=0x3; fetch issued at following IDLE; stall_out high until d_gnt.
- Backpressure: d_read, mem_ready low 3 cycles → mem_req held with constant mem_addr, d_gnt only on 4th REQ cycle, stall_out high throughout.
- Stray response: mem_rvalid pulsed in IDLE → no if_rvalid/d_rvalid.
- Reset in RESP: reset while awaiting read → next cycle IDLE, outputs zero, late mem_rvalid ignored.
- Fairness (MEM_ARB_FAIR_EN, STARVE_MAX=2): d_read held continuously with if_req → grants D,D,IF,D,D,IF; without macro all grants D.
